// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: function codes, FSM states and op classification.
package alu_pkg;

  localparam int unsigned ALU_CONTROL_WIDTH = 4;

  typedef enum logic [ALU_CONTROL_WIDTH-1:0] {
    OP_NOP = 4'b0000,
    OP_MUL = 4'b0001,
    OP_DIV = 4'b0010,
    OP_ROR = 4'b1000,
    OP_ROL = 4'b1001,
    OP_SLL = 4'b1010,
    OP_SLR = 4'b1011,
    OP_OR  = 4'b1100,
    OP_AND = 4'b1101,
    OP_SUB = 4'b1110,
    OP_ADD = 4'b1111
  } alu_op_t;

  typedef enum logic {IDLE, ITER} alu_mc_state_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit and alu_mc.
// ALU_MC_FLAGS_EN adds the registered zero/negative flags.
interface alu_mc_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  import alu_pkg::*;

  logic                         start;
  logic [DATA_WIDTH-1:0]        a;
  logic [DATA_WIDTH-1:0]        b;
  logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl;
  logic                         busy;
  logic                         done;
  logic [DATA_WIDTH-1:0]        r;
  logic [DATA_WIDTH-1:0]        s;
  logic                         alu_exception;
`ifdef ALU_MC_FLAGS_EN
  logic [1:0]                   flags;
`endif

  modport master (
    output start, a, b, alu_ctrl,
`ifdef ALU_MC_FLAGS_EN
    input  flags,
`endif
    input  busy, done, r, s, alu_exception
  );

  modport slave (
    input  start, a, b, alu_ctrl,
`ifdef ALU_MC_FLAGS_EN
    output flags,
`endif
    output busy, done, r, s, alu_exception
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per step.
// acc is the accumulator value after the current step ({upper/remainder, lower/quotient}).
module alu_muldiv_iter #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    op_is_div,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] acc
);

  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic                    is_div_q;

  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_hi;
  logic [DATA_WIDTH:0]     div_diff;
  logic [2*DATA_WIDTH-1:0] mul_next;
  logic [2*DATA_WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};
    // Partial remainder after the left shift keeps its carry bit for the trial subtract.
    div_hi   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
    div_diff = div_hi - {1'b0, b_q};
    if (!div_diff[DATA_WIDTH]) begin
      div_next = {div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_hi[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
    end
    acc = is_div_q ? div_next : mul_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      acc_q    <= {{DATA_WIDTH{1'b0}}, a};
      b_q      <= b;
      is_div_q <= op_is_div;
    end else if (step) begin
      acc_q    <= acc;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/busy/done handshake; MUL/DIV iterate DATA_WIDTH cycles.
// ALU_MC_FLAGS_EN adds flags = {negative, zero} registered with r.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] W_VEC    = DATA_WIDTH'(DATA_WIDTH);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  alu_mc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    busy_q, busy_d, done_q, done_d, exc_q, exc_d;
  logic [DATA_WIDTH-1:0]   r_q, r_d, s_q, s_d;
  logic                    load, step, go_iter;
  logic [2*DATA_WIDTH-1:0] acc;

  logic [DATA_WIDTH-1:0]   sc_r, sc_s, add_sum, sub_diff, rot_amt;
  logic                    sc_exc;
  logic [2*DATA_WIDTH-1:0] dbl, rol_full, ror_full;

  alu_muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .op_is_div(bus.alu_ctrl == OP_DIV),
    .a        (bus.a),
    .b        (bus.b),
    .acc      (acc)
  );

  always_comb begin
    sc_r     = '0;
    sc_s     = '0;
    sc_exc   = 1'b0;
    add_sum  = bus.a + bus.b;
    sub_diff = bus.a - bus.b;
    rot_amt  = bus.b % W_VEC;
    dbl      = {bus.a, bus.a};
    rol_full = dbl << rot_amt;
    ror_full = dbl >> rot_amt;
    case (bus.alu_ctrl)
      OP_ADD: begin
        sc_r   = add_sum;
        sc_exc = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        sc_r   = sub_diff;
        sc_exc = (bus.a[MSB] != bus.b[MSB]) && (sub_diff[MSB] != bus.a[MSB]);
      end
      OP_AND: sc_r = bus.a & bus.b;
      OP_OR:  sc_r = bus.a | bus.b;
      OP_SLL: sc_r = (bus.b >= W_VEC) ? '0 : (bus.a << bus.b);
      OP_SLR: sc_r = (bus.b >= W_VEC) ? '0 : (bus.a >> bus.b);
      OP_ROL: sc_r = rol_full[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_ROR: sc_r = ror_full[DATA_WIDTH-1:0];
      // Only the divide-by-zero case stays single-cycle.
      OP_DIV: begin
        sc_r   = '1;
        sc_s   = bus.a;
        sc_exc = 1'b1;
      end
      OP_MUL, OP_NOP: ;
      default: sc_exc = 1'b1;
    endcase
  end

  assign go_iter = is_multicycle(alu_op_t'(bus.alu_ctrl))
                   && !((bus.alu_ctrl == OP_DIV) && (bus.b == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    s_d     = s_q;
    exc_d   = exc_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (go_iter) begin
            load    = 1'b1;
            state_d = ITER;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            r_d    = sc_r;
            s_d    = sc_s;
            exc_d  = sc_exc;
            done_d = 1'b1;
          end
        end
      end
      ITER: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          r_d     = acc[DATA_WIDTH-1:0];
          s_d     = acc[2*DATA_WIDTH-1:DATA_WIDTH];
          exc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      s_q     <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      s_q     <= s_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.r             = r_q;
  assign bus.s             = s_q;
  assign bus.alu_exception = exc_q;

`ifdef ALU_MC_FLAGS_EN
  logic [1:0] flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else if (done_d) begin
      flags_q <= {r_d[MSB], r_d == '0};
    end
  end

  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed ops with literal expectations plus an arithmetic reference
// model compared every cycle. Define ALU_MC_FLAGS_EN to also cover the flags port.
module tb_alu_mc;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.DATA_WIDTH(W)) bus ();

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] s;
    logic        exc;
  } res_t;

  // Reference results straight from the arithmetic definition of each op.
  function automatic res_t model_op(logic [3:0] c, logic [15:0] a, logic [15:0] b);
    res_t o;
    int sa, sb, t;
    int unsigned ua, ub, n;
    longint unsigned p;
    o  = '0;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      4'hF: begin t = sa + sb; o.r = 16'(t); o.exc = (t > 32767) || (t < -32768); end
      4'hE: begin t = sa - sb; o.r = 16'(t); o.exc = (t > 32767) || (t < -32768); end
      4'hD: o.r = a & b;
      4'hC: o.r = a | b;
      4'hA: o.r = (ub >= 16) ? 16'h0 : 16'(ua << ub);
      4'hB: o.r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
      4'h9: begin n = ub % 16; o.r = 16'((ua << n) | (ua >> (16 - n))); end
      4'h8: begin n = ub % 16; o.r = 16'((ua >> n) | (ua << (16 - n))); end
      4'h1: begin p = longint'(ua) * longint'(ub); o.r = p[15:0]; o.s = p[31:16]; end
      4'h2: begin
        if (ub == 0) begin o.r = 16'hFFFF; o.s = a; o.exc = 1'b1; end
        else begin o.r = 16'(ua / ub); o.s = 16'(ua % ub); end
      end
      4'h0: ;
      default: o.exc = 1'b1;
    endcase
    return o;
  endfunction

  function automatic bit is_long(logic [3:0] c, logic [15:0] b);
    return (c == 4'h1) || (c == 4'h2 && b != 16'h0);
  endfunction

  logic        m_busy, m_done, m_exc;
  logic [15:0] m_r, m_s;
  logic [1:0]  m_flags;
  res_t        m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin : model
    res_t o;
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_exc   <= 1'b0;
      m_r     <= '0;
      m_s     <= '0;
      m_flags <= 2'b00;
      m_pend  <= '0;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_r     <= m_pend.r;
          m_s     <= m_pend.s;
          m_exc   <= m_pend.exc;
          m_flags <= {m_pend.r[15], m_pend.r == 16'h0};
        end
      end else if (bus.start) begin
        o = model_op(bus.alu_ctrl, bus.a, bus.b);
        if (is_long(bus.alu_ctrl, bus.b)) begin
          m_busy <= 1'b1;
          m_left <= W;
          m_pend <= o;
        end else begin
          m_done  <= 1'b1;
          m_r     <= o.r;
          m_s     <= o.s;
          m_exc   <= o.exc;
          m_flags <= {o.r[15], o.r == 16'h0};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy", bus.busy, m_busy);
      chk("cyc_done", bus.done, m_done);
      chk("cyc_r", bus.r, m_r);
      chk("cyc_s", bus.s, m_s);
      chk("cyc_exc", bus.alu_exception, m_exc);
`ifdef ALU_MC_FLAGS_EN
      chk("cyc_flags", bus.flags, m_flags);
`endif
    end
  end

  // Latency is counted in edges after the accept edge until done is seen.
  task automatic run_op(input string name, input logic [3:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [15:0] es,
                        input logic eexc, input int elat);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = c; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = b + 16'd3; bus.alu_ctrl = 4'h7;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_r"}, bus.r, er);
    chk({name, "_s"}, bus.s, es);
    chk({name, "_exc"}, bus.alu_exception, eexc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got no summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    int guard;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctrl = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_r", bus.r, 16'h0);
    chk("rst_s", bus.s, 16'h0);
    chk("rst_exc", bus.alu_exception, 1'b0);
    rst = 1'b0;
    chk_on = 1'b1;

    run_op("add_ovf", 4'hF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 0);
    run_op("sub_neg", 4'hE, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0, 0);
    run_op("sub_ovf", 4'hE, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 0);
    run_op("mul", 4'h1, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 16);
    run_op("mul_max", 4'h1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 16);
    run_op("div", 4'h2, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 16);
    run_op("div_max", 4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16);
    run_op("div_zero", 4'h2, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b1, 0);
    run_op("rol", 4'h9, 16'h8001, 16'd1, 16'h0003, 16'h0000, 1'b0, 0);
    run_op("ror", 4'h8, 16'h0001, 16'd17, 16'h8000, 16'h0000, 1'b0, 0);
    run_op("sll_wide", 4'hA, 16'h0001, 16'd16, 16'h0000, 16'h0000, 1'b0, 0);
    run_op("slr", 4'hB, 16'h8000, 16'd15, 16'h0001, 16'h0000, 1'b0, 0);
    run_op("undef", 4'h7, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 0);
    run_op("or", 4'hC, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 0);
    run_op("nop", 4'h0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b0, 0);
    run_op("sub_zero", 4'hE, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 1'b0, 0);
`ifdef ALU_MC_FLAGS_EN
    chk("flags_zero", bus.flags, 2'b01);
`endif
    run_op("and_neg", 4'hD, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 0);
`ifdef ALU_MC_FLAGS_EN
    chk("flags_neg", bus.flags, 2'b10);
`endif

    // A start pulse during a MUL must be dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = 4'h1; bus.a = 16'h1234; bus.b = 16'h0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_busy", bus.busy, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = 4'hF; bus.a = 16'h0001; bus.b = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.done && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ign_r", bus.r, 16'h2340);
    chk("ign_s", bus.s, 16'h0001);
    repeat (3) @(posedge clk); #1;
    chk("ign_nodone", bus.done, 1'b0);

    // Reset mid-MUL aborts it immediately with no completion.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = 4'h1; bus.a = 16'h00FF; bus.b = 16'h0101;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_r", bus.r, 16'h0);
    chk("abort_s", bus.s, 16'h0);
    chk("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_nodone", saw_done, 1'b0);
    run_op("div_after", 4'h2, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 16);
    run_op("mul_b2b", 4'h1, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 16);

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
